// File: rtl/cdc_sync_filter_if.sv
// Level-signal bundle between an asynchronous source and the synchronizing filter.
// The master drives the raw levels; the slave returns the synchronized word and its edge pulses.
interface cdc_sync_filter_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] async_i;
  logic [WIDTH-1:0] sync_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic             change_o;

  modport master (
    output async_i,
    input  sync_o,
    input  rise_o,
    input  fall_o,
    input  change_o
  );

  modport slave (
    input  async_i,
    output sync_o,
    output rise_o,
    output fall_o,
    output change_o
  );
endinterface

// File: rtl/cdc_sync_filter.sv
// N-stage level synchronizer with optional whole-word stability filter and per-bit edge pulses.
// Latency STAGES edges unfiltered, STAGES+1+FILTER_LEN filtered; no backpressure, inputs are quasi-static levels.
module cdc_sync_filter #(
  parameter int unsigned      WIDTH      = 1,
  parameter int unsigned      STAGES     = 2,
  parameter int unsigned      FILTER_LEN = 0,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  cdc_sync_filter_if.slave  bus
);

  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic [WIDTH-1:0]             s_out;
  logic [WIDTH-1:0]             sync_val;
  logic [WIDTH-1:0]             prev_q;

  // Pure flop chain: nothing may sit between stages or metastability settling time is lost.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_q <= {STAGES{RESET_VAL}};
    end else begin
      s_q <= {s_q[STAGES-2:0], bus.async_i};
    end
  end

  assign s_out = s_q[STAGES-1];

  generate
    if (FILTER_LEN == 0) begin : g_nofilt
      assign sync_val = s_out;
    end else begin : g_filt
      localparam int unsigned      CNT_W    = $clog2(FILTER_LEN + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

      logic [WIDTH-1:0] cand_q, cand_d;
      logic [WIDTH-1:0] sync_q, sync_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Any bit moving restarts the count, so only words that sat still at s_out get through.
      always_comb begin
        cand_d = cand_q;
        sync_d = sync_q;
        cnt_d  = '0;
        if (s_out != cand_q) begin
          cand_d = s_out;
        end else if (cand_q != sync_q) begin
          if (cnt_q == CNT_LAST) begin
            sync_d = cand_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
          cand_q <= RESET_VAL;
          sync_q <= RESET_VAL;
          cnt_q  <= '0;
        end else begin
          cand_q <= cand_d;
          sync_q <= sync_d;
          cnt_q  <= cnt_d;
        end
      end

      assign sync_val = sync_q;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= RESET_VAL;
    end else begin
      prev_q <= sync_val;
    end
  end

  assign bus.sync_o   = sync_val;
  assign bus.rise_o   = sync_val & ~prev_q;
  assign bus.fall_o   = ~sync_val & prev_q;
  assign bus.change_o = |(sync_val ^ prev_q);

endmodule

// File: tb/tb_cdc_sync_filter.sv
// Directed bench for cdc_sync_filter: five instances cover reset release, unfiltered steps,
// glitch rejection, incoherent words, simultaneous edges and mid-count reset.
module tb_cdc_sync_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d, rst_e;
  int   n_vec = 0;
  int   n_err = 0;

  cdc_sync_filter_if #(.WIDTH(8)) if_a ();
  cdc_sync_filter_if #(.WIDTH(1)) if_b ();
  cdc_sync_filter_if #(.WIDTH(1)) if_c ();
  cdc_sync_filter_if #(.WIDTH(8)) if_d ();
  cdc_sync_filter_if #(.WIDTH(1)) if_e ();

  cdc_sync_filter #(.WIDTH(8), .STAGES(2), .FILTER_LEN(0), .RESET_VAL(8'h00))
    dut_a (.clk_i(clk), .rst_ni(rst_a), .bus(if_a));
  cdc_sync_filter #(.WIDTH(1), .STAGES(3), .FILTER_LEN(0), .RESET_VAL(1'b0))
    dut_b (.clk_i(clk), .rst_ni(rst_b), .bus(if_b));
  cdc_sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_LEN(3), .RESET_VAL(1'b0))
    dut_c (.clk_i(clk), .rst_ni(rst_c), .bus(if_c));
  cdc_sync_filter #(.WIDTH(8), .STAGES(2), .FILTER_LEN(2), .RESET_VAL(8'h00))
    dut_d (.clk_i(clk), .rst_ni(rst_d), .bus(if_d));
  cdc_sync_filter #(.WIDTH(1), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(1'b0))
    dut_e (.clk_i(clk), .rst_ni(rst_e), .bus(if_e));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] es, input logic [7:0] er,
                       input logic [7:0] ef, input logic ec);
    chk({tag, ".sync"},   if_a.sync_o,          es);
    chk({tag, ".rise"},   if_a.rise_o,          er);
    chk({tag, ".fall"},   if_a.fall_o,          ef);
    chk({tag, ".change"}, 8'(if_a.change_o),    8'(ec));
  endtask

  task automatic chk_b(input string tag, input logic es, input logic er,
                       input logic ef, input logic ec);
    chk({tag, ".sync"},   8'(if_b.sync_o),      8'(es));
    chk({tag, ".rise"},   8'(if_b.rise_o),      8'(er));
    chk({tag, ".fall"},   8'(if_b.fall_o),      8'(ef));
    chk({tag, ".change"}, 8'(if_b.change_o),    8'(ec));
  endtask

  task automatic chk_c(input string tag, input logic es, input logic er,
                       input logic ef, input logic ec);
    chk({tag, ".sync"},   8'(if_c.sync_o),      8'(es));
    chk({tag, ".rise"},   8'(if_c.rise_o),      8'(er));
    chk({tag, ".fall"},   8'(if_c.fall_o),      8'(ef));
    chk({tag, ".change"}, 8'(if_c.change_o),    8'(ec));
  endtask

  task automatic chk_d(input string tag, input logic [7:0] es, input logic [7:0] er,
                       input logic [7:0] ef, input logic ec);
    chk({tag, ".sync"},   if_d.sync_o,          es);
    chk({tag, ".rise"},   if_d.rise_o,          er);
    chk({tag, ".fall"},   if_d.fall_o,          ef);
    chk({tag, ".change"}, 8'(if_d.change_o),    8'(ec));
  endtask

  task automatic chk_e(input string tag, input logic es, input logic er,
                       input logic ef, input logic ec);
    chk({tag, ".sync"},   8'(if_e.sync_o),      8'(es));
    chk({tag, ".rise"},   8'(if_e.rise_o),      8'(er));
    chk({tag, ".fall"},   8'(if_e.fall_o),      8'(ef));
    chk({tag, ".change"}, 8'(if_e.change_o),    8'(ec));
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0; rst_e = 1'b0;
    if_a.async_i = 8'hFF;
    if_b.async_i = 1'b0;
    if_c.async_i = 1'b0;
    if_d.async_i = 8'h00;
    if_e.async_i = 1'b0;

    // Reset release with all-ones held at the input
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1; rst_e = 1'b1;
    step(); chk_a("rel_e1", 8'h00, 8'h00, 8'h00, 1'b0);
    step(); chk_a("rel_e2", 8'hFF, 8'hFF, 8'h00, 1'b1);
    step(); chk_a("rel_e3", 8'hFF, 8'h00, 8'h00, 1'b0);

    // Unfiltered 3-stage step up then down
    if_b.async_i = 1'b1;
    step(); chk_b("up_e1", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_b("up_e2", 1'b0, 1'b0, 1'b0, 1'b0);
    step(); chk_b("up_e3", 1'b1, 1'b1, 1'b0, 1'b1);
    step(); chk_b("up_e4", 1'b1, 1'b0, 1'b0, 1'b0);
    if_b.async_i = 1'b0;
    step(); chk_b("dn_e1", 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_b("dn_e2", 1'b1, 1'b0, 1'b0, 1'b0);
    step(); chk_b("dn_e3", 1'b0, 1'b0, 1'b1, 1'b1);
    step(); chk_b("dn_e4", 1'b0, 1'b0, 1'b0, 1'b0);

    // Glitch of 3 cycles is rejected with L=3, a 4+ cycle level passes at edge 6
    if_c.async_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_c("glitch_hi", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if_c.async_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(); chk_c("glitch_lo", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if_c.async_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); chk_c("clean_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(); chk_c("clean_e6", 1'b1, 1'b1, 1'b0, 1'b1);
    step(); chk_c("clean_e7", 1'b1, 1'b0, 1'b0, 1'b0);

    // Incoherent word: 0x5A for 2 cycles must never surface
    if_d.async_i = 8'h5A;
    step(); chk_d("incoh_e1", 8'h00, 8'h00, 8'h00, 1'b0);
    step(); chk_d("incoh_e2", 8'h00, 8'h00, 8'h00, 1'b0);
    if_d.async_i = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      step(); chk_d("incoh_wait", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    step(); chk_d("incoh_e7", 8'hA5, 8'hA5, 8'h00, 1'b1);
    step(); chk_d("incoh_e8", 8'hA5, 8'h00, 8'h00, 1'b0);

    // Mixed rise/fall on different bits in the same cycle
    if_d.async_i = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      step(); chk_d("to0f_wait", 8'hA5, 8'h00, 8'h00, 1'b0);
    end
    step(); chk_d("to0f_e5", 8'h0F, 8'h0A, 8'hA0, 1'b1);
    step(); chk_d("to0f_e6", 8'h0F, 8'h00, 8'h00, 1'b0);
    if_d.async_i = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_d("simul_wait", 8'h0F, 8'h00, 8'h00, 1'b0);
    end
    step(); chk_d("simul_e5", 8'hF0, 8'hF0, 8'h0F, 1'b1);
    step(); chk_d("simul_e6", 8'hF0, 8'h00, 8'h00, 1'b0);

    // Reset for one cycle with the count at 2 (L=4)
    if_e.async_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); chk_e("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_e = 1'b0;
    step(); chk_e("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_e = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(); chk_e("post_rst_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(); chk_e("post_rst_e7", 1'b1, 1'b1, 1'b0, 1'b1);
    step(); chk_e("post_rst_e8", 1'b1, 1'b0, 1'b0, 1'b0);

    // Input returns to the output value before the count completes: no update
    if_e.async_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_e("cancel_lo", 1'b1, 1'b0, 1'b0, 1'b0);
    end
    if_e.async_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(); chk_e("cancel_hi", 1'b1, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
